// File: rtl/rd_alu_pkg.sv
// Shared types for rd_alu_mc: op encodings, FSM states, result flag bundle.
// Latency: n/a (types and a pure decode helper only).
// Backpressure: n/a. RD_ALU_SIGNED_DIV_EN adds DIV/REM to the iterative op set.
package rd_alu_pkg;

   // ADD..SRA keep the legacy combinational rd_alu encodings.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_MUL  = 4'd8,
      ALU_DIVU = 4'd9,
      ALU_REMU = 4'd10,
      ALU_DIV  = 4'd11,
      ALU_REM  = 4'd12
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic negative;
      logic illegal;
   } alu_flags_t;

   // Ops that go through the bit-serial datapath instead of the one-cycle path.
   function automatic logic is_iter_op(input alu_op_t op);
      logic r;
      r = (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`ifdef RD_ALU_SIGNED_DIV_EN
      r = r || (op == ALU_DIV) || (op == ALU_REM);
`endif
      return r;
   endfunction

endpackage

// File: rtl/rd_alu_iter.sv
// Bit-serial shift-add multiplier / restoring divider shared by MUL, DIVU, REMU (and DIV/REM).
// Latency: result and done_o presented combinationally in the XLEN-th busy cycle after start_i.
// Backpressure: none; caller only pulses start_i when idle. Signed path under RD_ALU_SIGNED_DIV_EN.
module rd_alu_iter
   import rd_alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  alu_op_t         op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            done_o,
   output logic [XLEN-1:0] res_o,
   output logic            ovf_o
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mul_q, mul_d;
   logic             rem_q, rem_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             ovf_q, ovf_d;
   // acc: product (MUL) or partial remainder (divide)
   // x:   shifted multiplicand (MUL) or dividend shifting out / quotient shifting in
   // y:   multiplier shifting right (MUL) or divisor
   logic [XLEN-1:0]  acc_q, acc_d, x_q, x_d, y_q, y_d;

   logic             sgn, a_neg, b_neg;
   logic [XLEN-1:0]  a_mag, b_mag;
   logic [XLEN:0]    shl, trial;

   // Operand conditioning at start: signed divides run on magnitudes.
   always_comb begin
`ifdef RD_ALU_SIGNED_DIV_EN
      sgn = (op_i == ALU_DIV) || (op_i == ALU_REM);
`else
      sgn = 1'b0;
`endif
      a_neg = sgn && a_i[XLEN-1];
      b_neg = sgn && b_i[XLEN-1];
      a_mag = a_neg ? ('0 - a_i) : a_i;
      b_mag = b_neg ? ('0 - b_i) : b_i;
   end

   // One multiply/divide step per busy cycle; result comes from the step's next value.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      mul_d  = mul_q;
      rem_d  = rem_q;
      negq_d = negq_q;
      negr_d = negr_q;
      ovf_d  = ovf_q;
      acc_d  = acc_q;
      x_d    = x_q;
      y_d    = y_q;
      shl    = {acc_q, x_q[XLEN-1]};
      trial  = shl - {1'b0, y_q};
      done_o = busy_q && (cnt_q == CNT_W'(XLEN-1));

      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         mul_d  = (op_i == ALU_MUL);
         rem_d  = (op_i == ALU_REMU) || (op_i == ALU_REM);
         acc_d  = '0;
         x_d    = (op_i == ALU_MUL) ? a_i : a_mag;
         y_d    = (op_i == ALU_MUL) ? b_i : b_mag;
         // Zero divisor keeps the natural all-ones quotient, so no sign flip then.
         negq_d = (a_neg ^ b_neg) && (b_i != '0);
         negr_d = a_neg;
         ovf_d  = sgn && (a_i == MIN_VAL) && (b_i == '1);
      end else if (busy_q) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (done_o) begin
            busy_d = 1'b0;
         end
         if (mul_q) begin
            acc_d = acc_q + (y_q[0] ? x_q : '0);
            x_d   = x_q << 1;
            y_d   = y_q >> 1;
         end else if (!trial[XLEN]) begin
            acc_d = trial[XLEN-1:0];
            x_d   = {x_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = shl[XLEN-1:0];
            x_d   = {x_q[XLEN-2:0], 1'b0};
         end
      end

      if (mul_q) begin
         res_o = acc_d;
      end else if (rem_q) begin
         res_o = negr_q ? ('0 - acc_d) : acc_d;
      end else begin
         res_o = negq_q ? ('0 - x_d) : x_d;
      end
   end

   assign ovf_o = ovf_q;

   // Datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         mul_q  <= 1'b0;
         rem_q  <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         ovf_q  <= 1'b0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         mul_q  <= mul_d;
         rem_q  <= rem_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         ovf_q  <= ovf_d;
         acc_q  <= acc_d;
         x_q    <= x_d;
         y_q    <= y_d;
      end
   end

endmodule

// File: rtl/rd_alu_mc.sv
// Execute-stage ALU with registered result/flags and iterative MUL/DIVU/REMU (DIV/REM with RD_ALU_SIGNED_DIV_EN).
// Latency: single-cycle ops 1 clock after accept; iterative ops XLEN+1 clocks after accept.
// Backpressure: result held while ready_in=0; ready_o drops when busy or when holding an unaccepted result.
module rd_alu_mc
   import rd_alu_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            valid_in,
   output logic            ready_o,
   input  logic [XLEN-1:0] A_in,
   input  logic [XLEN-1:0] B_in,
   input  logic [3:0]      op_in,
   output logic            valid_o,
   input  logic            ready_in,
   output logic [XLEN-1:0] C_o,
   output logic            zero_o,
   output logic            carry_o,
   output logic            overflow_o,
   output logic            negative_o,
   output logic            illegal_o
);

   state_t           state_q, state_d;
   logic [XLEN-1:0]  c_q, c_d;
   alu_flags_t       flg_q, flg_d;

   alu_op_t          op;
   logic [SHAMT_W-1:0] shamt;
   logic [XLEN:0]    sum, dif;
   logic [XLEN-1:0]  alu_c;
   alu_flags_t       alu_f;
   logic             accept;

   logic             iter_start, iter_done, iter_ovf;
   logic [XLEN-1:0]  iter_res;

   assign op    = alu_op_t'(op_in);
   assign shamt = B_in[SHAMT_W-1:0];

   // Single-cycle result and flags straight from the presented operands.
   always_comb begin
      alu_c = '0;
      alu_f = '0;
      sum   = {1'b0, A_in} + {1'b0, B_in};
      dif   = {1'b0, A_in} - {1'b0, B_in};
      case (op)
         ALU_ADD: begin
            alu_c          = sum[XLEN-1:0];
            alu_f.carry    = sum[XLEN];
            alu_f.overflow = (A_in[XLEN-1] == B_in[XLEN-1]) && (sum[XLEN-1] != A_in[XLEN-1]);
         end
         ALU_SUB: begin
            alu_c          = dif[XLEN-1:0];
            alu_f.carry    = ~dif[XLEN];
            alu_f.overflow = (A_in[XLEN-1] != B_in[XLEN-1]) && (dif[XLEN-1] != A_in[XLEN-1]);
         end
         ALU_AND: alu_c = A_in & B_in;
         ALU_OR:  alu_c = A_in | B_in;
         ALU_XOR: alu_c = A_in ^ B_in;
         ALU_SLL: alu_c = A_in << shamt;
         ALU_SRL: alu_c = A_in >> shamt;
         ALU_SRA: alu_c = $signed(A_in) >>> shamt;
         ALU_MUL, ALU_DIVU, ALU_REMU: ;
`ifdef RD_ALU_SIGNED_DIV_EN
         ALU_DIV, ALU_REM: ;
`endif
         default: alu_f.illegal = 1'b1;
      endcase
      alu_f.zero     = (alu_c == '0);
      alu_f.negative = alu_c[XLEN-1];
   end

   // Control FSM: acceptance, iterative launch, result capture and hold.
   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      flg_d      = flg_q;
      ready_o    = 1'b0;
      iter_start = 1'b0;
      case (state_q)
         IDLE: ready_o = 1'b1;
         BUSY: begin
            if (iter_done) begin
               c_d            = iter_res;
               flg_d          = '0;
               flg_d.zero     = (iter_res == '0);
               flg_d.negative = iter_res[XLEN-1];
               flg_d.overflow = iter_ovf;
               state_d        = DONE;
            end
         end
         DONE: begin
            ready_o = ready_in;
            if (ready_in) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      accept = valid_in && ready_o;
      if (accept) begin
         if (is_iter_op(op)) begin
            iter_start = 1'b1;
            state_d    = BUSY;
         end else begin
            c_d     = alu_c;
            flg_d   = alu_f;
            state_d = DONE;
         end
      end
   end

   // State register.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output result and flag registers.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         c_q   <= '0;
         flg_q <= '0;
      end else begin
         c_q   <= c_d;
         flg_q <= flg_d;
      end
   end

   rd_alu_iter #(
      .XLEN (XLEN)
   ) u_iter (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .start_i (iter_start),
      .op_i    (op),
      .a_i     (A_in),
      .b_i     (B_in),
      .done_o  (iter_done),
      .res_o   (iter_res),
      .ovf_o   (iter_ovf)
   );

   assign valid_o    = (state_q == DONE);
   assign C_o        = c_q;
   assign zero_o     = flg_q.zero;
   assign carry_o    = flg_q.carry;
   assign overflow_o = flg_q.overflow;
   assign negative_o = flg_q.negative;
   assign illegal_o  = flg_q.illegal;

endmodule

// File: tb/tb_rd_alu_mc.sv
// Directed bench for rd_alu_mc (XLEN=64) with a result scoreboard.
// Latency: checks single-cycle (1) and iterative (XLEN+1) result timing.
// Backpressure: exercises output hold under ready_in=0 and reset abort.
module tb_rd_alu_mc;
   import rd_alu_pkg::*;

   localparam int XLEN = 64;
   localparam logic [4:0] F_Z = 5'b10000;
   localparam logic [4:0] F_C = 5'b01000;
   localparam logic [4:0] F_V = 5'b00100;
   localparam logic [4:0] F_N = 5'b00010;
   localparam logic [4:0] F_I = 5'b00001;

   logic            clk_in = 1'b0;
   logic            rst_in, valid_in, ready_in, ready_o, valid_o;
   logic [XLEN-1:0] A_in, B_in, C_o;
   logic [3:0]      op_in;
   logic            zero_o, carry_o, overflow_o, negative_o, illegal_o;

   typedef struct {
      string       name;
      logic [63:0] c;
      logic [4:0]  f;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   first_cyc = 0;
   bit   fresh = 1'b1;

   rd_alu_mc #(.XLEN(XLEN)) dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .valid_in   (valid_in),
      .ready_o    (ready_o),
      .A_in       (A_in),
      .B_in       (B_in),
      .op_in      (op_in),
      .valid_o    (valid_o),
      .ready_in   (ready_in),
      .C_o        (C_o),
      .zero_o     (zero_o),
      .carry_o    (carry_o),
      .overflow_o (overflow_o),
      .negative_o (negative_o),
      .illegal_o  (illegal_o)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one op (caller is at posedge+1), wait for acceptance, log the expectation.
   task automatic send(input string name, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] ec, input logic [4:0] ef,
                       input int lat);
      int   n;
      exp_t e;
      n = 0;
      valid_in = 1'b1; op_in = op; A_in = a; B_in = b;
      while (!ready_o && n < 300) begin
         @(posedge clk_in); #1;
         n++;
      end
      chk({name, "/accept"}, {63'd0, ready_o}, 64'd1);
      e.name = name; e.c = ec; e.f = ef; e.lat = lat; e.acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk_in); #1;
      valid_in = 1'b0;
      op_in    = 4'($urandom);
      A_in     = {$urandom, $urandom};
      B_in     = {$urandom, $urandom};
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk_in); #1;
         n++;
      end
      chk({name, "/drain"}, 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: pops the scoreboard on each completed output handshake.
   always @(negedge clk_in) begin
      exp_t e;
      if (rst_in) begin
         fresh = 1'b1;
      end else if (valid_o === 1'b1) begin
         if (fresh) begin
            first_cyc = cyc;
            fresh     = 1'b0;
         end
         if (ready_in) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               chk({e.name, "/C_o"}, C_o, e.c);
               chk({e.name, "/flags"}, {59'd0, zero_o, carry_o, overflow_o, negative_o, illegal_o},
                   {59'd0, e.f});
               if (e.lat >= 0) chk({e.name, "/latency"}, 64'(first_cyc - e.acc), 64'(e.lat));
            end
            fresh = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      int n;
      int vcnt;
      rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
      op_in = 4'd0; A_in = '0; B_in = '0;
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;

      // Reset state
      chk("reset/valid_o", {63'd0, valid_o}, 64'd0);
      chk("reset/ready_o", {63'd0, ready_o}, 64'd1);
      chk("reset/C_o", C_o, 64'd0);
      chk("reset/flags", {59'd0, zero_o, carry_o, overflow_o, negative_o, illegal_o}, 64'd0);

      // Single-cycle ops
      send("add", ALU_ADD, 64'h10, 64'h20, 64'h30, 5'b0, 0);
      drain("add");
      send("srl", ALU_SRL, 64'h8000000000000000, 64'h1F, 64'h0000000100000000, 5'b0, 0);
      send("sra", ALU_SRA, 64'h8000000000000000, 64'h3F, 64'hFFFFFFFFFFFFFFFF, F_N, 0);
      send("sll_wrap", ALU_SLL, 64'h3, 64'h41, 64'h6, 5'b0, 0);
      send("and", ALU_AND, 64'hF0F0, 64'hFF00, 64'hF000, 5'b0, 0);
      send("or", ALU_OR, 64'hF0F0, 64'hFF00, 64'hFFF0, 5'b0, 0);
      send("xor_zero", ALU_XOR, 64'hFF, 64'hFF, 64'h0, F_Z, 0);
      send("add_carry", ALU_ADD, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, F_Z | F_C, 0);
      send("sub_borrow", ALU_SUB, 64'h10, 64'h20, 64'hFFFFFFFFFFFFFFF0, F_N, 0);
      send("sub_eq", ALU_SUB, 64'h5, 64'h5, 64'h0, F_Z | F_C, 0);
      send("illegal_f", 4'hF, 64'h1234, 64'h5678, 64'h0, F_Z | F_I, 0);
      send("illegal_d", 4'hD, 64'h1, 64'h1, 64'h0, F_Z | F_I, 0);
      drain("single");

      // Iterative ops
      send("mul", ALU_MUL, 64'h10, 64'h20, 64'h200, 5'b0, 64);
      busy = 0; n = 0;
      while (!valid_o && n < 300) begin
         if (!ready_o) busy++;
         @(posedge clk_in); #1;
         n++;
      end
      chk("mul/busy_cycles", 64'(busy), 64'd64);
      drain("mul");
      send("divu", ALU_DIVU, 64'd100, 64'd7, 64'd14, 5'b0, 64);
      send("remu", ALU_REMU, 64'd100, 64'd7, 64'd2, 5'b0, 64);
      send("mul_wrap", ALU_MUL, 64'hFFFFFFFFFFFFFFFF, 64'd3, 64'hFFFFFFFFFFFFFFFD, F_N, 64);
      send("divu_big", ALU_DIVU, 64'hFFFFFFFFFFFFFFFF, 64'h10, 64'h0FFFFFFFFFFFFFFF, 5'b0, 64);
      send("remu_big", ALU_REMU, 64'hFFFFFFFFFFFFFFFF, 64'h10, 64'hF, 5'b0, 64);
      send("divu_by0", ALU_DIVU, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, F_N, 64);
      send("remu_by0", ALU_REMU, 64'd5, 64'd0, 64'd5, 5'b0, 64);
      drain("iter");

      // Back-to-back: single -> iterative -> single
      send("b2b_add", ALU_ADD, 64'd1, 64'd2, 64'd3, 5'b0, 0);
      send("b2b_mul", ALU_MUL, 64'd6, 64'd7, 64'd42, 5'b0, 64);
      send("b2b_sub", ALU_SUB, 64'd9, 64'd4, 64'd5, F_C, 0);
      drain("b2b");

`ifdef RD_ALU_SIGNED_DIV_EN
      send("div_ovf", ALU_DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
           64'h8000000000000000, F_V | F_N, 64);
      send("div_neg", ALU_DIV, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, F_N, 64);
      send("rem_neg", ALU_REM, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, F_N, 64);
      send("div_by0", ALU_DIV, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, F_N, 64);
      send("rem_by0", ALU_REM, 64'hFFFFFFFFFFFFFFFB, 64'd0, 64'hFFFFFFFFFFFFFFFB, F_N, 64);
`else
      send("div_illegal", ALU_DIV, 64'd100, 64'd7, 64'd0, F_Z | F_I, 0);
      send("rem_illegal", ALU_REM, 64'd100, 64'd7, 64'd0, F_Z | F_I, 0);
`endif
      drain("signed");

      // Backpressure: result held, new inputs ignored while ready_in=0
      ready_in = 1'b0;
      send("bp_add", ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'h8000000000000000, F_V | F_N, 0);
      valid_in = 1'b1; op_in = ALU_SUB; A_in = 64'd123; B_in = 64'd456;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         chk("bp/valid_o", {63'd0, valid_o}, 64'd1);
         chk("bp/C_o", C_o, 64'h8000000000000000);
         chk("bp/overflow_o", {63'd0, overflow_o}, 64'd1);
         chk("bp/negative_o", {63'd0, negative_o}, 64'd1);
         chk("bp/ready_o", {63'd0, ready_o}, 64'd0);
         @(posedge clk_in); #1;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      drain("bp");

      // Reset 10 cycles into a MUL aborts it
      send("mul_abort", ALU_MUL, 64'd5, 64'd7, 64'd35, 5'b0, 64);
      repeat (9) begin
         @(posedge clk_in); #1;
      end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      sb.delete();
      chk("abort/valid_o", {63'd0, valid_o}, 64'd0);
      chk("abort/ready_o", {63'd0, ready_o}, 64'd1);
      vcnt = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk_in);
         if (valid_o) vcnt++;
      end
      chk("abort/no_result", 64'(vcnt), 64'd0);
      @(posedge clk_in); #1;
      send("sub_after_rst", ALU_SUB, 64'h20, 64'h10, 64'h10, F_C, 0);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
